// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative multiply/divide unit with the HI/LO register pair.
//
// Runs MULT, MULTU, DIV and DIVU next to the ALU. A one-cycle i_Start in IDLE
// launches an operation. Each CALC cycle does one radix-2 step: shift-add for
// multiply, restoring subtract for divide. FIXUP applies the result signs and
// writes HI/LO. DONE raises o_Done for one cycle.
//
// Optional build macro: MDU_EARLY_TERM_EN
//   When defined, a multiply leaves CALC as soon as the multiplier bits not yet
//   consumed are all zero. FIXUP then shifts the accumulator into place, so the
//   product is unchanged and only the latency varies.
//
// Ports:
//   i_clk, i_reset_n      clock (rising edge), asynchronous active-low reset
//   i_Start, i_Op         start pulse (IDLE only); 00 MULT 01 MULTU 10 DIV 11 DIVU
//   i_RegA, i_RegB        rs / rt operands
//   i_WrHi, i_WrLo        MTHI / MTLO write enables (IDLE only), data on i_WrData
//   o_Busy                high in CALC, FIXUP and DONE
//   o_Done, o_DivZero     result pulse; divide-by-zero flag in the same cycle
//   o_Hi, o_Lo            HI / LO registers
module mult_div_unit #(
  parameter int NBITS   = 32,
  parameter int CNTBITS = 6
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_Start,
  input  logic [1:0]       i_Op,
  input  logic [NBITS-1:0] i_RegA,
  input  logic [NBITS-1:0] i_RegB,
  input  logic             i_WrHi,
  input  logic             i_WrLo,
  input  logic [NBITS-1:0] i_WrData,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_DivZero,
  output logic [NBITS-1:0] o_Hi,
  output logic [NBITS-1:0] o_Lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2, DONE = 2'd3} state_t;

  state_t state_reg, state_next;

  // The accumulator holds {partial product, multiplier} or {remainder, quotient}.
  // In both cases the low half starts as the operand that is consumed one bit
  // per step.
  logic [2*NBITS-1:0] acc_reg;
  logic [NBITS-1:0]   opnd_reg;      // multiplicand or divisor magnitude
  logic [CNTBITS-1:0] cnt_reg;       // completed CALC iterations
  logic               is_div_reg;
  logic               res_neg_reg;   // product / quotient must be negated
  logic               dvd_neg_reg;   // remainder must be negated
  logic               div_zero_reg;
  logic [NBITS-1:0]   hi_reg, lo_reg;

  // Start decode
  logic             op_signed, op_div, start_div_zero;
  logic [NBITS-1:0] mag_a, mag_b;

  assign op_signed      = ~i_Op[0];
  assign op_div         = i_Op[1];
  assign start_div_zero = op_div && (i_RegB == '0);
  assign mag_a          = (op_signed && i_RegA[NBITS-1]) ? -i_RegA : i_RegA;
  assign mag_b          = (op_signed && i_RegB[NBITS-1]) ? -i_RegB : i_RegB;

  // Multiply step: add the multiplicand when the multiplier LSB is set, then
  // shift the whole accumulator right. The sum carry becomes the new top bit.
  logic [NBITS:0]     mul_sum;
  logic [2*NBITS-1:0] mul_step;

  assign mul_sum  = {1'b0, acc_reg[2*NBITS-1:NBITS]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_step = {mul_sum, acc_reg[NBITS-1:1]};

  // Restoring divide step. The shifted remainder needs NBITS+1 bits. When the
  // subtraction succeeds, the result is below the divisor, so a wrapping
  // NBITS-wide subtract gives the exact new remainder.
  logic [NBITS:0]     rem_shift;
  logic               div_ge;
  logic [NBITS-1:0]   div_rem;
  logic [2*NBITS-1:0] div_step;

  assign rem_shift = acc_reg[2*NBITS-1:NBITS-1];
  assign div_ge    = rem_shift >= {1'b0, opnd_reg};
  assign div_rem   = rem_shift[NBITS-1:0] - opnd_reg;
  assign div_step  = div_ge ? {div_rem, acc_reg[NBITS-2:0], 1'b1}
                            : {acc_reg[2*NBITS-2:0], 1'b0};

  logic               calc_last;
  logic [2*NBITS-1:0] prod_mag;

`ifdef MDU_EARLY_TERM_EN
  localparam int CW = CNTBITS + 1;

  logic [NBITS-1:0] mplier_reg;   // multiplier bits not yet consumed
  logic [CW-1:0]    align_amt;

  // Exit once the bits left after this step are all zero. The remaining steps
  // would only shift, so FIXUP does that shift in one go.
  assign calc_last = (cnt_reg == CNTBITS'(NBITS - 1)) ||
                     (!is_div_reg && ((mplier_reg >> 1) == '0));
  assign align_amt = CW'(NBITS) - {1'b0, cnt_reg};
  assign prod_mag  = acc_reg >> align_amt;
`else
  assign calc_last = (cnt_reg == CNTBITS'(NBITS - 1));
  assign prod_mag  = acc_reg;
`endif

  // Result fixup
  logic [2*NBITS-1:0] prod;
  logic [NBITS-1:0]   quo, rem;

  assign prod = res_neg_reg ? -prod_mag : prod_mag;
  assign quo  = res_neg_reg ? -acc_reg[NBITS-1:0] : acc_reg[NBITS-1:0];
  assign rem  = dvd_neg_reg ? -acc_reg[2*NBITS-1:NBITS] : acc_reg[2*NBITS-1:NBITS];

  // FSM
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (i_Start) state_next = start_div_zero ? DONE : CALC;
      CALC:    if (calc_last) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_reg      <= '0;
      opnd_reg     <= '0;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      res_neg_reg  <= 1'b0;
      dvd_neg_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
`ifdef MDU_EARLY_TERM_EN
      mplier_reg   <= '0;
`endif
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (i_WrHi) hi_reg <= i_WrData;
          if (i_WrLo) lo_reg <= i_WrData;
          if (i_Start) begin
            acc_reg      <= {{NBITS{1'b0}}, (op_div ? mag_a : mag_b)};
            opnd_reg     <= op_div ? mag_b : mag_a;
            cnt_reg      <= '0;
            is_div_reg   <= op_div;
            res_neg_reg  <= op_signed && (i_RegA[NBITS-1] ^ i_RegB[NBITS-1]);
            dvd_neg_reg  <= op_signed && op_div && i_RegA[NBITS-1];
            div_zero_reg <= start_div_zero;
`ifdef MDU_EARLY_TERM_EN
            mplier_reg   <= mag_b;
`endif
          end
        end
        CALC: begin
          acc_reg <= is_div_reg ? div_step : mul_step;
          cnt_reg <= cnt_reg + CNTBITS'(1);
`ifdef MDU_EARLY_TERM_EN
          mplier_reg <= mplier_reg >> 1;
`endif
        end
        FIXUP: begin
          if (is_div_reg) begin
            lo_reg <= quo;
            hi_reg <= rem;
          end else begin
            hi_reg <= prod[2*NBITS-1:NBITS];
            lo_reg <= prod[NBITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Busy    = (state_reg != IDLE);
  assign o_Done    = (state_reg == DONE);
  assign o_DivZero = (state_reg == DONE) && div_zero_reg;
  assign o_Hi      = hi_reg;
  assign o_Lo      = lo_reg;

endmodule
